logic16_arbiter: RTL and testbench



---
 rtl/logic16_pkg.sv | 22 ++
 rtl/logic16_unit.sv | 44 ++++
 rtl/logic16_arbiter.sv | 130 +++++++++++++
 tb/tb_logic16_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/logic16_pkg.sv
// Shared types and constants for the 16-bit logic-unit arbiter.
// Opcode encodings, controller state enum and the basic NAND primitive.
package logic16_pkg;

    typedef logic [15:0] word_t;

    localparam logic [1:0] OP_NOT = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic nand2(input logic a, input logic b);
        return ~(a & b);
    endfunction

endpackage

// File: rtl/logic16_unit.sv
// Combinational 16-bit NOT/AND/OR/XOR, every function composed purely
// of two-input NAND gates per bit, with the result picked by opcode.
module logic16_unit
    import logic16_pkg::*;
(
    input  logic [1:0] i_op,
    input  word_t      i_a,
    input  word_t      i_b,
    output word_t      o_y
);

    word_t w_not;
    word_t w_and;
    word_t w_or;
    word_t w_xor;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_bit
            logic w_nab;
            logic w_na;
            logic w_nb;
            assign w_nab      = nand2(i_a[gi], i_b[gi]);
            assign w_na       = nand2(i_a[gi], i_a[gi]);
            assign w_nb       = nand2(i_b[gi], i_b[gi]);
            assign w_not[gi]  = w_na;
            assign w_and[gi]  = nand2(w_nab, w_nab);
            assign w_or[gi]   = nand2(w_na, w_nb);
            // Classic four-NAND XOR sharing the a-nand-b term.
            assign w_xor[gi]  = nand2(nand2(i_a[gi], w_nab), nand2(i_b[gi], w_nab));
        end
    endgenerate

    always_comb begin
        o_y = w_not;
        case (i_op)
            OP_NOT:  o_y = w_not;
            OP_AND:  o_y = w_and;
            OP_OR:   o_y = w_or;
            OP_XOR:  o_y = w_xor;
            default: o_y = w_not;
        endcase
    end

endmodule

// File: rtl/logic16_arbiter.sv
// Arbitrates NUM_REQ requesters onto one logic16_unit and returns a tagged,
// registered result. Define LOGIC16_ARB_RR_EN for round-robin; default is fixed priority.
module logic16_arbiter
    import logic16_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     i_req_valid,
    output logic [NUM_REQ-1:0]     o_req_ready,
    input  logic [2*NUM_REQ-1:0]   i_req_op,
    input  logic [16*NUM_REQ-1:0]  i_req_a,
    input  logic [16*NUM_REQ-1:0]  i_req_b,
    output logic                   o_resp_valid,
    input  logic                   i_resp_ready,
    output word_t                  o_resp_data,
    output logic [ID_W-1:0]        o_resp_id,
    output logic                   o_busy
);

    state_t            r_state;
    state_t            w_state_next;
    logic [1:0]        r_op;
    word_t             r_a;
    word_t             r_b;
    logic [ID_W-1:0]   r_id;
    word_t             r_resp_data;
    word_t             w_unit_y;

    logic [ID_W-1:0]   w_grant_id;
    logic              w_grant_any;
    logic [NUM_REQ-1:0] w_grant;
    logic              w_accept;

`ifdef LOGIC16_ARB_RR_EN
    logic [ID_W-1:0]   r_ptr;
    logic [ID_W-1:0]   w_idx;

    // Search starts one past the last winner and wraps at NUM_REQ-1.
    always_comb begin
        w_grant_id  = '0;
        w_grant_any = 1'b0;
        w_idx       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = ID_W'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_grant_any && i_req_valid[w_idx]) begin
                w_grant_id  = w_idx;
                w_grant_any = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= ID_W'(NUM_REQ - 1);
        end else if (w_accept) begin
            r_ptr <= w_grant_id;
        end
    end
`else
    // Scan downwards so the lowest valid index is the last to win.
    always_comb begin
        w_grant_id  = '0;
        w_grant_any = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (i_req_valid[ID_W'(k)]) begin
                w_grant_id  = ID_W'(k);
                w_grant_any = 1'b1;
            end
        end
    end
`endif

    assign w_grant     = w_grant_any ? (NUM_REQ'(1) << w_grant_id) : '0;
    assign w_accept    = (r_state == ST_IDLE) && w_grant_any;
    assign o_req_ready = (r_state == ST_IDLE) ? w_grant : '0;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_grant_any) w_state_next = ST_EXEC;
            ST_EXEC: w_state_next = ST_RESP;
            ST_RESP: if (i_resp_ready) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op        <= OP_NOT;
            r_a         <= '0;
            r_b         <= '0;
            r_id        <= '0;
            r_resp_data <= '0;
        end else begin
            if (w_accept) begin
                r_op <= i_req_op[2*w_grant_id +: 2];
                r_a  <= i_req_a[16*w_grant_id +: 16];
                r_b  <= i_req_b[16*w_grant_id +: 16];
                r_id <= w_grant_id;
            end
            if (r_state == ST_EXEC) begin
                r_resp_data <= w_unit_y;
            end
        end
    end

    logic16_unit u_unit (
        .i_op (r_op),
        .i_a  (r_a),
        .i_b  (r_b),
        .o_y  (w_unit_y)
    );

    assign o_resp_valid = (r_state == ST_RESP);
    assign o_resp_data  = r_resp_data;
    assign o_resp_id    = r_id;
    assign o_busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_logic16_arbiter.sv
// Scoreboard bench for logic16_arbiter: drivers push expected results,
// a negedge monitor checks every presented response, grants and latency.
module tb_logic16_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic [2*NUM_REQ-1:0]  req_op = '0;
    logic [16*NUM_REQ-1:0] req_a = '0;
    logic [16*NUM_REQ-1:0] req_b = '0;
    logic                  resp_valid;
    logic                  resp_ready = 1'b1;
    logic [15:0]           resp_data;
    logic [ID_W-1:0]       resp_id;
    logic                  busy;

    logic16_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_op     (req_op),
        .i_req_a      (req_a),
        .i_req_b      (req_b),
        .o_resp_valid (resp_valid),
        .i_resp_ready (resp_ready),
        .o_resp_data  (resp_data),
        .o_resp_id    (resp_id),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    int   grant_q[$];
    int   acc_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   viol = 0;
    int   cyc = 0;
    int   last_acc = -100;
    logic prev_rv = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: grants, latency, response data/id against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy && req_ready != '0) viol++;
            if (!$onehot0(req_ready)) viol++;
            if ((req_valid & req_ready) != '0) begin
                for (int i = 0; i < NUM_REQ; i++)
                    if (req_ready[i]) grant_q.push_back(i);
                acc_q.push_back(cyc);
                last_acc = cyc;
                $display("accept id=%0d cycle=%0d", $clog2(int'(req_ready)), cyc);
            end
            if (resp_valid && !prev_rv) check("resp_latency", cyc - last_acc, 2);
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", 1, 0);
                end else begin
                    check("resp_data", resp_data, exp_q[0].data);
                    check("resp_id", resp_id, exp_q[0].id);
                    if (resp_ready) begin
                        $display("resp id=%0d data=%h exp_id=%0d exp_data=%h",
                                 resp_id, resp_data, exp_q[0].id, exp_q[0].data);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
        prev_rv = resp_valid;
    end

    // Called just after a rising edge; returns just after the accept edge.
    task automatic issue(input int id, input logic [1:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] exp_data);
        exp_t e;
        bit   got = 0;
        req_op[2*id +: 2] = op;
        req_a[16*id +: 16] = a;
        req_b[16*id +: 16] = b;
        req_valid[id] = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (req_ready[id]) got = 1;
        end
        if (!got) check("grant_timeout", 0, 1);
        e.data = exp_data;
        e.id   = id;
        if (got) exp_q.push_back(e);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) done = 1;
        end
        if (!done) check("idle_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_resp_valid"}, resp_valid, 0);
        check({tag, "_resp_data"}, resp_data, 16'h0000);
        check({tag, "_resp_id"}, resp_id, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int exp_ids[5];
        logic [15:0] exp_dat[5];

        // Reset values
        #12;
        check_reset_outputs("por");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // NOT, basic latency
        issue(0, 2'b00, 16'h00FF, 16'h1234, 16'hFF00);
        wait_idle();

        // XOR under 5 cycles of backpressure, competing requester held off
        resp_ready = 1'b0;
        issue(2, 2'b11, 16'hAAAA, 16'hFFFF, 16'h5555);
        req_op[2*1 +: 2] = 2'b01;
        req_a[16*1 +: 16] = 16'hFFFF;
        req_b[16*1 +: 16] = 16'hFFFF;
        req_valid[1] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("hold_req_ready", req_ready, 0);
        end
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        resp_ready = 1'b1;
        wait_idle();

        // Reset during EXEC discards the op
        issue(1, 2'b01, 16'h1234, 16'h0F0F, 16'h0204);
        rst_n = 1'b0;
        exp_q.delete();
        #2;
        check_reset_outputs("mid");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_no_resp", resp_valid, 0);

        // All requesters valid continuously: five accepts
`ifdef LOGIC16_ARB_RR_EN
        exp_ids = '{0, 1, 2, 3, 0};
`else
        exp_ids = '{0, 0, 0, 0, 0};
`endif
        req_op = {2'b11, 2'b10, 2'b01, 2'b00};
        req_a  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        req_b  = {16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF};
        for (int i = 0; i < 5; i++) begin
            exp_t e;
            case (exp_ids[i])
                0: exp_dat[i] = 16'hEEEE;
                1: exp_dat[i] = 16'h0022;
                2: exp_dat[i] = 16'h33FF;
                default: exp_dat[i] = 16'h44BB;
            endcase
            e.data = exp_dat[i];
            e.id   = exp_ids[i];
            exp_q.push_back(e);
        end
        base = grant_q.size();
        req_valid = '1;
        begin
            int cnt = 0;
            for (int i = 0; i < 100 && cnt < 5; i++) begin
                @(negedge clk);
                if ((req_valid & req_ready) != '0) cnt++;
            end
            if (cnt < 5) check("rr_accept_count", cnt, 5);
        end
        @(posedge clk); #1;
        req_valid = '0;
        wait_idle();
        check("grant_count", grant_q.size() - base, 5);
        for (int i = 0; i < 5; i++)
            if (base + i < grant_q.size()) check("grant_order", grant_q[base + i], exp_ids[i]);

        // OR from req 3, then back-to-back XOR spaced 3 cycles
        base = acc_q.size();
        issue(3, 2'b10, 16'h8000, 16'h0001, 16'h8001);
        req_valid[3] = 1'b1;
        issue(3, 2'b11, 16'hFFFF, 16'h0F0F, 16'hF0F0);
        wait_idle();
        if (acc_q.size() >= base + 2) check("b2b_spacing", acc_q[base + 1] - acc_q[base], 3);
        else check("b2b_accepts", acc_q.size() - base, 2);

        check("scoreboard_empty", exp_q.size(), 0);
        check("ready_invariants", viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
